ysyx_22051013_bpu_resolve: RTL and testbench

//  EX-side resolver for static fetch-stage branch prediction.
//  IF pushes each predicted branch/JAL record into an in-order prediction queue. EX pops the oldest record when that branch resolves.
//  On a mismatch the block issues a one-cycle redirect+flush with the corrected PC and discards all younger records.
//  It also keeps saturating branch and mispredict counters for perf reporting.

---
 rtl/ysyx_22051013_bpu_resolve.sv | 195 +++++++++++++++++++
 tb/tb_ysyx_22051013_bpu_resolve.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051013_bpu_resolve.sv
// ysyx_22051013_bpu_resolve
// EX-side resolver for static fetch-stage branch prediction. IF pushes one
// record per predicted branch/JAL into an in-order queue. EX pops the oldest
// record when that branch resolves. A wrong prediction produces a one-cycle
// redirect+flush carrying the corrected PC, and every younger record is dropped.
// Saturating branch and mispredict counters are kept for perf reporting.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high. Ready never depends on the same-cycle valid. pred_ready and
// res_ready are functions of registered state only. An offer that is not
// accepted may be changed or withdrawn freely; nothing is latched.
module ysyx_22051013_bpu_resolve #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 64,
    parameter int              CNT_W    = 32,
    parameter logic [PC_W-1:0] START_PC = PC_W'(64'h8000_0000)
) (
    input  logic                       clk,
    input  logic                       rst,
    // prediction records from IF
    input  logic                       pred_valid,
    input  logic [PC_W-1:0]            pred_pc,
    input  logic                       pred_taken,
    input  logic [PC_W-1:0]            pred_target,
    output logic                       pred_ready,
    // resolution of the oldest outstanding branch from EX
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic [PC_W-1:0]            res_target,
    output logic                       res_ready,
    // redirect towards IF/ID
    output logic                       redirect_valid,
    output logic [PC_W-1:0]            redirect_pc,
    output logic                       flush,
    // status and perf
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [CNT_W-1:0]           cnt_branch,
    output logic [CNT_W-1:0]           cnt_mispred,
    output logic                       err_underflow,
    // current FSM state (0 = RUN, 1 = FLUSH)
    output logic                       dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int QC_W  = PTR_W + 1;
    localparam logic [QC_W-1:0] DEPTH_C = QC_W'(DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // state
    // ------------------------------------------------------------------
    state_e              state_q;
    logic [PTR_W-1:0]    head_q;
    logic [PTR_W-1:0]    tail_q;
    logic [QC_W-1:0]     count_q;
    logic                redirect_valid_q;
    logic [PC_W-1:0]     redirect_pc_q;
    logic [CNT_W-1:0]    cnt_branch_q;
    logic [CNT_W-1:0]    cnt_mispred_q;
    logic                err_underflow_q;

    // queue payload; no reset needed because occupancy is tracked by count_q
    logic [PC_W-1:0]     ent_pc_q     [DEPTH];
    logic                ent_taken_q  [DEPTH];
    logic [PC_W-1:0]     ent_target_q [DEPTH];

    // ------------------------------------------------------------------
    // combinational decode
    // ------------------------------------------------------------------
    logic                in_run;
    logic                push;
    logic                pop;
    logic [PC_W-1:0]     head_pc;
    logic                head_taken;
    logic [PC_W-1:0]     head_target;
    logic                mispredict;
    logic                pop_mis;
    logic                pop_ok;
    logic                underflow;
    logic [PC_W-1:0]     correct_pc;

    // handshake decode and head-entry comparison
    always_comb begin
        in_run      = (state_q == ST_RUN);
        pred_ready  = in_run && (count_q < DEPTH_C);
        res_ready   = in_run && (count_q != '0);
        push        = pred_valid && pred_ready;
        pop         = res_valid && res_ready;

        head_pc     = ent_pc_q[head_q];
        head_taken  = ent_taken_q[head_q];
        head_target = ent_target_q[head_q];

        // direction wrong, or taken to a different place than predicted
        mispredict  = (head_taken != res_taken) ||
                      (res_taken && (head_target != res_target));
        pop_mis     = pop && mispredict;
        pop_ok      = pop && !mispredict;

        // a resolve with nothing outstanding is a protocol error; FLUSH-cycle
        // inputs are wrong-path and do not count
        underflow   = in_run && res_valid && (count_q == '0);

        correct_pc  = res_taken ? res_target : (head_pc + PC_W'(4));
    end

    // payload write for accepted pushes; a push that coincides with a
    // mispredicting pop is dropped, so it is not written either
    always_ff @(posedge clk) begin
        if (push && !pop_mis) begin
            ent_pc_q[tail_q]     <= pred_pc;
            ent_taken_q[tail_q]  <= pred_taken;
            ent_target_q[tail_q] <= pred_target;
        end
    end

    // FSM, queue pointers, redirect output and perf counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_RUN;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= START_PC;
            cnt_branch_q     <= '0;
            cnt_mispred_q    <= '0;
            err_underflow_q  <= 1'b0;
        end else begin
            redirect_valid_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (underflow) begin
                        err_underflow_q <= 1'b1;
                    end

                    if (pop && (cnt_branch_q != '1)) begin
                        cnt_branch_q <= cnt_branch_q + CNT_W'(1);
                    end
                    if (pop_mis && (cnt_mispred_q != '1)) begin
                        cnt_mispred_q <= cnt_mispred_q + CNT_W'(1);
                    end

                    if (pop_mis) begin
                        // wrong path: discard every record and refetch
                        state_q          <= ST_FLUSH;
                        head_q           <= '0;
                        tail_q           <= '0;
                        count_q          <= '0;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= correct_pc;
                    end else begin
                        if (push) begin
                            tail_q <= tail_q + PTR_W'(1);
                        end
                        if (pop_ok) begin
                            head_q <= head_q + PTR_W'(1);
                        end
                        if (push && !pop_ok) begin
                            count_q <= count_q + QC_W'(1);
                        end else if (!push && pop_ok) begin
                            count_q <= count_q - QC_W'(1);
                        end
                    end
                end

                ST_FLUSH: begin
                    // one bubble cycle: everything offered now is wrong-path
                    state_q <= ST_RUN;
                end

                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // outputs
    // ------------------------------------------------------------------
    assign redirect_valid = redirect_valid_q;
    assign flush          = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign q_count        = count_q;
    assign cnt_branch     = cnt_branch_q;
    assign cnt_mispred    = cnt_mispred_q;
    assign err_underflow  = err_underflow_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_ysyx_22051013_bpu_resolve.sv
// Bench for ysyx_22051013_bpu_resolve: directed scenarios followed by random
// traffic, all compared against a queue-based reference model. Counters use a
// narrow width so that saturation is reachable in a short run.
module tb_ysyx_22051013_bpu_resolve;

  localparam int DEPTH = 4;
  localparam int PC_W  = 64;
  localparam int CNT_W = 4;
  localparam logic [63:0] START_PC = 64'h8000_0000;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             pred_valid, pred_taken, pred_ready;
  logic [PC_W-1:0]  pred_pc, pred_target;
  logic             res_valid, res_taken, res_ready;
  logic [PC_W-1:0]  res_target;
  logic             redirect_valid, flush, err_underflow, dbg_state;
  logic [PC_W-1:0]  redirect_pc;
  logic [2:0]       q_count;
  logic [CNT_W-1:0] cnt_branch, cnt_mispred;

  ysyx_22051013_bpu_resolve #(
    .DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W), .START_PC(START_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .res_ready(res_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .q_count(q_count), .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred),
    .err_underflow(err_underflow), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [63:0] pc;
    logic        taken;
    logic [63:0] target;
  } rec_t;

  rec_t        mq[$];
  bit          m_flush;
  logic [63:0] m_rpc;
  int          m_cb, m_cm;
  bit          m_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic int sat_inc(input int v);
    int max_v = (1 << CNT_W) - 1;
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_flush = 0;
    m_rpc   = START_PC;
    m_cb    = 0;
    m_cm    = 0;
    m_err   = 0;
  endtask

  // what one clock edge does, given the inputs that were applied
  task automatic model_step(input bit pv, input logic [63:0] ppc, input bit pt,
                            input logic [63:0] ptg, input bit rv, input bit rt,
                            input logic [63:0] rtg);
    rec_t h, n;
    bit   can_push, can_pop, mis;
    if (m_flush) begin
      m_flush = 0;
      return;
    end
    can_push = pv && (mq.size() < DEPTH);
    can_pop  = rv && (mq.size() > 0);
    if (rv && mq.size() == 0) m_err = 1;
    n.pc = ppc; n.taken = pt; n.target = ptg;
    if (can_pop) begin
      h    = mq[0];
      mis  = (h.taken != rt) || (rt && h.target != rtg);
      m_cb = sat_inc(m_cb);
      if (mis) begin
        m_cm    = sat_inc(m_cm);
        m_rpc   = rt ? rtg : h.pc + 64'd4;
        m_flush = 1;
        mq.delete();
        return;
      end
      void'(mq.pop_front());
    end
    if (can_push) mq.push_back(n);
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".pred_ready"},  64'(pred_ready),     64'(!m_flush && mq.size() < DEPTH));
    check({ctx, ".res_ready"},   64'(res_ready),      64'(!m_flush && mq.size() > 0));
    check({ctx, ".redirect"},    64'(redirect_valid), 64'(m_flush));
    check({ctx, ".flush"},       64'(flush),          64'(m_flush));
    check({ctx, ".state"},       64'(dbg_state),      64'(m_flush));
    check({ctx, ".redirect_pc"}, redirect_pc,         m_rpc);
    check({ctx, ".q_count"},     64'(q_count),        64'(mq.size()));
    check({ctx, ".cnt_branch"},  64'(cnt_branch),     64'(m_cb));
    check({ctx, ".cnt_mispred"}, 64'(cnt_mispred),    64'(m_cm));
    check({ctx, ".err"},         64'(err_underflow),  64'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  // called at a negedge: apply inputs, clock once, then compare at the next negedge
  task automatic cycle(input string ctx, input bit pv, input logic [63:0] ppc,
                       input bit pt, input logic [63:0] ptg, input bit rv,
                       input bit rt, input logic [63:0] rtg);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    @(posedge clk);
    model_step(pv, ppc, pt, ptg, rv, rt, rtg);
    @(negedge clk);
    pred_valid = 0; res_valid = 0;
    compare_all(ctx);
  endtask

  task automatic push(input string ctx, input logic [63:0] pc, input bit t, input logic [63:0] tg);
    cycle(ctx, 1, pc, t, tg, 0, 0, 0);
  endtask

  task automatic resolve(input string ctx, input bit t, input logic [63:0] tg);
    cycle(ctx, 0, 0, 0, 0, 1, t, tg);
  endtask

  task automatic idle(input string ctx);
    cycle(ctx, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0;

    // 1: correct not-taken prediction
    do_reset();
    push("t1.push", 64'h8000_0000, 0, 64'h8000_0004);
    resolve("t1.res", 0, 0);
    check("t1.cnt_branch", 64'(cnt_branch), 64'd1);
    check("t1.no_redirect", 64'(redirect_valid), 64'd0);
    check("t1.q_count", 64'(q_count), 64'd0);

    // 2: predicted taken, actually not taken -> redirect to pc+4
    push("t2.push", 64'h8000_0010, 1, 64'h8000_0000);
    resolve("t2.res", 0, 0);
    check("t2.redirect", 64'(redirect_valid & flush), 64'd1);
    check("t2.redirect_pc", redirect_pc, 64'h8000_0014);
    check("t2.cnt_mispred", 64'(cnt_mispred), 64'd1);
    idle("t2.after");
    check("t2.pulse_ends", 64'(redirect_valid), 64'd0);

    // 3: fill, overflow push, push+pop while full
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      push("t3.fill", 64'h8000_1000 + 64'(i * 16), 0, 0);
    check("t3.full_ready", 64'(pred_ready), 64'd0);
    push("t3.overflow", 64'h8000_2000, 0, 0);
    check("t3.count_full", 64'(q_count), 64'd4);
    cycle("t3.pushpop", 1, 64'h8000_3000, 0, 0, 1, 0, 0);
    check("t3.count_after", 64'(q_count), 64'd3);

    // 4: head mispredicts on target with a same-cycle push
    do_reset();
    push("t4.p0", 64'h8000_0020, 1, 64'h8000_0200);
    push("t4.p1", 64'h8000_0030, 0, 0);
    push("t4.p2", 64'h8000_0040, 0, 0);
    cycle("t4.mis", 1, 64'h8000_0050, 0, 0, 1, 1, 64'h8000_0100);
    check("t4.count", 64'(q_count), 64'd0);
    check("t4.redirect_pc", redirect_pc, 64'h8000_0100);
    push("t4.flush_push", 64'h8000_0060, 0, 0);
    check("t4.flush_push_dropped", 64'(q_count), 64'd0);

    // 5: underflow is sticky, counters untouched
    do_reset();
    resolve("t5.underflow", 1, 64'h1234);
    check("t5.err", 64'(err_underflow), 64'd1);
    check("t5.cnt_branch", 64'(cnt_branch), 64'd0);
    push("t5.push", 64'h8000_0070, 0, 0);
    resolve("t5.res", 0, 0);
    check("t5.err_sticky", 64'(err_underflow), 64'd1);

    // 5b: drive both counters into saturation with repeated mispredicts
    for (int i = 0; i < 18; i++) begin
      push("t5.sat_push", 64'h8000_0080, 0, 0);
      resolve("t5.sat_res", 1, 64'h8000_0900);
      idle("t5.sat_idle");
    end
    check("t5.cnt_branch_sat", 64'(cnt_branch), 64'(CNT_MAX));
    check("t5.cnt_mispred_sat", 64'(cnt_mispred), 64'(CNT_MAX));

    // 6: asynchronous reset while in FLUSH
    push("t6.push", 64'h8000_00a0, 1, 64'h8000_0300);
    resolve("t6.mis", 0, 0);
    check("t6.in_flush", 64'(redirect_valid), 64'd1);
    #2;
    rst = 0;
    model_reset();
    #1;
    check("t6.redirect_valid", 64'(redirect_valid), 64'd0);
    check("t6.redirect_pc", redirect_pc, 64'h8000_0000);
    check("t6.q_count", 64'(q_count), 64'd0);
    @(negedge clk);
    compare_all("t6.held");
    rst = 1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit          pv, pt, rv, rt;
      logic [63:0] ppc, ptg, rtg;
      pv  = ($urandom_range(0, 3) != 0);
      ppc = {32'h0000_0000, 32'h8000_0000 + ($urandom_range(0, 255) << 2)};
      pt  = $urandom_range(0, 1);
      ptg = {32'h0000_0000, 32'h8000_0000 + ($urandom_range(0, 255) << 2)};
      rv  = ($urandom_range(0, 2) != 0);
      rt  = $urandom_range(0, 1);
      rtg = {32'h0000_0000, 32'h8000_0000 + ($urandom_range(0, 255) << 2)};
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt  = mq[0].taken;
        rtg = mq[0].target;
      end
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle("rand", pv, ppc, pt, ptg, rv, rt, rtg);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // hard bound on simulated time
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
